// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory load/store unit.
package dmem_pkg;

    // RISC-V funct3 encodings for loads and stores
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } dmem_state_e;

    // Stores only exist in signed B/H/W form; unsigned variants are load-only.
    function automatic logic size_ok(input logic [2:0] size, input logic store);
        logic ld_ok;
        ld_ok = (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
                (size == SZ_BU) || (size == SZ_HU);
        return store ? (size == SZ_B) || (size == SZ_H) || (size == SZ_W) : ld_ok;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: byte-lane steering for stores and load extraction/extension.
//   size_i     funct3 access size
//   lane_i     byte offset within the word
//   wdata_i    right-aligned store data
//   rword_i    raw word read from the array
//   be_o       per-byte write enables
//   wword_o    store data replicated onto its lanes
//   ldata_o    load data shifted to bit 0 and sign/zero extended
//   misalign_o access crosses its natural alignment
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [31:0] sh;

    always_comb begin
        sh         = rword_i >> {lane_i, 3'b000};
        be_o       = (size_i == SZ_B) ? 4'b0001 << lane_i :
                     (size_i == SZ_H) ? 4'b0011 << lane_i :
                     (size_i == SZ_W) ? 4'b1111 : 4'b0000;
        // replicating the data lets the byte enables pick the right lane
        wword_o    = (size_i == SZ_B) ? {4{wdata_i[7:0]}} :
                     (size_i == SZ_H) ? {2{wdata_i[15:0]}} : wdata_i;
        ldata_o    = (size_i == SZ_B)  ? {{24{sh[7]}}, sh[7:0]} :
                     (size_i == SZ_BU) ? {24'b0, sh[7:0]} :
                     (size_i == SZ_H)  ? {{16{sh[15]}}, sh[15:0]} :
                     (size_i == SZ_HU) ? {16'b0, sh[15:0]} : rword_i;
        misalign_o = (((size_i == SZ_H) || (size_i == SZ_HU)) && lane_i[0]) ||
                     ((size_i == SZ_W) && (lane_i != 2'b00));
    end

endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte/half/word load-store unit over a word array, registered response.
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_req, i_wren    request valid, 1 = store
//   i_addr, i_wdata  byte address, right-aligned store data
//   i_size           funct3 access size
//   o_ready          accepting requests (READY state)
//   o_rsp_valid      response pulse for the previous cycle's request
//   o_rdata, o_fault formatted load data and fault code, zero when idle
//   o_busy           post-reset clear in progress
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_wren,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_size,
    output logic        o_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_fault,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0]  mem_q [DEPTH];
    dmem_state_e  state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic         rsp_valid_q;
    logic [31:0]  rdata_q, rdata_d;
    fault_e       fault_q, fault_d;

    logic          accept, in_range, misalign, st_we, init_we;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wword, ldata;

    dmem_lane_fmt u_fmt (
        .size_i    (i_size),
        .lane_i    (i_addr[1:0]),
        .wdata_i   (i_wdata),
        .rword_i   (mem_q[widx]),
        .be_o      (be),
        .wword_o   (wword),
        .ldata_o   (ldata),
        .misalign_o(misalign)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        if (state_q == ST_INIT) begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == LAST) ? ST_READY : ST_INIT;
        end
        accept   = i_req & o_ready;
        widx     = i_addr[AW+1:2];
        in_range = ~|i_addr[31:AW+2];
        fault_d  = !accept                    ? FLT_NONE :
                   !size_ok(i_size, i_wren)   ? FLT_RANGE :
                   misalign                   ? FLT_MISALIGN :
                   !in_range                  ? FLT_RANGE : FLT_NONE;
        st_we    = accept & i_wren & (fault_d == FLT_NONE) & ~i_reset;
        init_we  = (state_q == ST_INIT) & ~i_reset;
        rdata_d  = (accept & ~i_wren & (fault_d == FLT_NONE)) ? ldata : 32'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= INIT_CLEAR ? ST_INIT : ST_READY;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= FLT_NONE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rsp_valid_q <= accept;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    // array has no reset; the INIT sweep provides defined contents
    always_ff @(posedge i_clk) begin
        if (init_we) begin
            mem_q[idx_q] <= '0;
        end else if (st_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[widx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

    assign o_ready     = (state_q == ST_READY);
    assign o_busy      = (state_q == ST_INIT);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rdata     = rdata_q;
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed self-checking bench for data_memory_lsu.
module tb_data_memory_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset, i_req, i_wren;
    logic [31:0] i_addr, i_wdata;
    logic [2:0]  i_size;
    logic        o_ready, o_rsp_valid, o_busy;
    logic [31:0] o_rdata;
    logic [1:0]  o_fault;

    int n_cmp = 0;
    int n_err = 0;

    data_memory_lsu #(.DEPTH(256), .INIT_CLEAR(1'b1)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_wren     (i_wren),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_size     (i_size),
        .o_ready    (o_ready),
        .o_rsp_valid(o_rsp_valid),
        .o_rdata    (o_rdata),
        .o_fault    (o_fault),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // issue one request (accepted at the next edge) and check its response
    task automatic op(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] s,
                      input logic [31:0] exp_rd, input logic [1:0] exp_f);
        i_req = 1'b1; i_wren = w; i_addr = a; i_wdata = d; i_size = s;
        tick();
        check({tag, ".valid"}, {31'b0, o_rsp_valid}, 32'd1);
        check({tag, ".rdata"}, o_rdata, exp_rd);
        check({tag, ".fault"}, {30'b0, o_fault}, {30'b0, exp_f});
    endtask

    // count cycles spent busy, flagging any ready/response while clearing
    task automatic wait_init(input string tag, input int exp_cycles);
        int n   = 0;
        int bad = 0;
        while (o_busy && n < 1000) begin
            n++;
            if (o_ready || o_rsp_valid) bad++;
            tick();
        end
        check({tag, ".init_cycles"}, n, exp_cycles);
        check({tag, ".init_quiet"}, bad, 0);
        check({tag, ".ready_after"}, {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        i_reset = 1'b1; i_req = 1'b1; i_wren = 1'b0;
        i_addr = 32'h3FC; i_wdata = '0; i_size = 3'b010;
        tick();
        i_reset = 1'b0;
        check("rst.valid", {31'b0, o_rsp_valid}, 32'd0);
        check("rst.rdata", o_rdata, 32'd0);
        check("rst.fault", {30'b0, o_fault}, 32'd0);
        check("rst.ready", {31'b0, o_ready}, 32'd0);
        check("rst.busy",  {31'b0, o_busy}, 32'd1);
        wait_init("init1", 256);

        op("lw_3fc",  1'b0, 32'h3FC, 32'h0,        3'b010, 32'h0,        2'b00);
        op("sw_10",   1'b1, 32'h10,  32'h8899AABB, 3'b010, 32'h0,        2'b00);
        op("sb_11",   1'b1, 32'h11,  32'h000000CC, 3'b000, 32'h0,        2'b00);
        op("lw_10",   1'b0, 32'h10,  32'h0,        3'b010, 32'h8899CCBB, 2'b00);
        op("lb_11",   1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFFCC, 2'b00);
        op("lbu_11",  1'b0, 32'h11,  32'h0,        3'b100, 32'h000000CC, 2'b00);
        op("lh_12",   1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFF8899, 2'b00);
        op("lhu_12",  1'b0, 32'h12,  32'h0,        3'b101, 32'h00008899, 2'b00);
        op("sh_20",   1'b1, 32'h20,  32'h00001234, 3'b001, 32'h0,        2'b00);
        op("lw_20",   1'b0, 32'h20,  32'h0,        3'b010, 32'h00001234, 2'b00);
        op("sw_22",   1'b1, 32'h22,  32'hFFFFFFFF, 3'b010, 32'h0,        2'b01);
        op("lw_20b",  1'b0, 32'h20,  32'h0,        3'b010, 32'h00001234, 2'b00);
        op("lh_21",   1'b0, 32'h21,  32'h0,        3'b001, 32'h0,        2'b01);
        op("lw_400",  1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        2'b10);
        op("ld_sz3",  1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        2'b10);
        op("sb_sz4",  1'b1, 32'h10,  32'h00000055, 3'b100, 32'h0,        2'b10);
        op("lw_10b",  1'b0, 32'h10,  32'h0,        3'b010, 32'h8899CCBB, 2'b00);

        i_req = 1'b0;
        tick();
        check("idle.valid", {31'b0, o_rsp_valid}, 32'd0);
        check("idle.rdata", o_rdata, 32'd0);

        i_req = 1'b1; i_wren = 1'b0; i_addr = 32'h10; i_size = 3'b010; i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("rst2.valid", {31'b0, o_rsp_valid}, 32'd0);
        check("rst2.busy",  {31'b0, o_busy}, 32'd1);
        wait_init("init2", 256);
        op("lw_10c",  1'b0, 32'h10,  32'h0,        3'b010, 32'h0,        2'b00);

        i_req = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor to the single-cycle word data memory.
- Adds RISC-V byte/half/word loads and stores with byte lanes and sign/zero extension.
- Adds misalignment and out-of-range fault detection, a registered one-cycle response with a valid/ready handshake, and a post-reset clear sequencer.
- Sits between the core's MEM stage and the data array; one request per cycle.

Parameters:
DEPTH, 256, number of 32-bit words (power of two, 4..65536)
INIT_CLEAR, 1, 1 = zero every word after reset via the INIT state; 0 = skip INIT (contents undefined)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_req  in  1  request valid
i_wren  in  1  1 = store, 0 = load
i_addr  in  32  byte address
i_wdata  in  32  store data, right-aligned
i_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
o_ready  out  1  block accepts a request this cycle
o_rsp_valid  out  1  one-cycle pulse, response for the request accepted the previous cycle
o_rdata  out  32  formatted load data; 0 for stores and faults
o_fault  out  2  00 ok, 01 misaligned, 10 out-of-range or illegal size
o_busy  out  1  INIT clear in progress

Behaviour:
- Reset: sample i_reset high at a rising edge. Outputs next cycle: o_rsp_valid=0, o_rdata=0, o_fault=00, o_ready=0.
  - State goes to INIT (INIT_CLEAR=1) with clear index 0, or to READY (INIT_CLEAR=0).
  - o_busy=1 while in INIT.
- Reset mid-operation: any in-flight response is dropped; INIT restarts from index 0.
- States:
  - INIT: write 0 to word[idx] each cycle, idx++. At idx==DEPTH-1, the write completes and the state goes to READY. INIT lasts exactly DEPTH cycles.
  - READY: o_ready=1.
- Requests seen while o_ready=0 are ignored; no response is generated.
- Accept = i_req & o_ready. Every accepted request produces exactly one o_rsp_valid pulse, the cycle after acceptance.
  - Throughput is one request per cycle.
  - o_rdata and o_fault are valid only with o_rsp_valid. Otherwise they hold 0 / 00.
- Word index = i_addr[31:2]; lane = i_addr[1:0].
- Fault priority:
  - Illegal i_size (011, 110, 111, and stores with 100/101) -> 10.
  - Else misaligned (H/HU with lane[0]=1; W with lane!=00) -> 01.
  - Else word index >= DEPTH -> 10.
  - A faulting request does not modify memory and returns o_rdata=0.
- Stores:
  - B: byte lane = i_addr[1:0], data = i_wdata[7:0].
  - H: lanes {lane+1, lane}, data = i_wdata[15:0].
  - W: all lanes.
  - Unselected bytes are preserved.
  - The write commits at the accepting edge.
  - Response: o_rdata=0, fault code.
- Loads:
  - Array read is registered at the accepting edge.
  - The selected byte/half is shifted to bits [7:0]/[15:0].
  - B/H sign-extend; BU/HU zero-extend.
- Ordering: a load accepted the cycle after a store to the same word returns the stored data. There is no same-cycle hazard, because only one request is accepted per cycle.
- No combinational path from i_req to o_rsp_valid or o_rdata.
- o_ready is a function of state only.

Decomposition:
- Package dmem_pkg:
  - mem_size_e enum (SZ_B=3'b000, SZ_H=001, SZ_W=010, SZ_BU=100, SZ_HU=101).
  - fault_e (FLT_NONE, FLT_MISALIGN, FLT_RANGE).
  - dmem_state_e (ST_INIT, ST_READY).
- Sub-module dmem_lane_fmt (combinational, shared by the load and store paths):
  - Inputs: size, lane, wdata, rword.
  - Outputs: byte-enable [3:0], lane-shifted write word, extended load data, misalign flag.

Test Plan:
- INIT_CLEAR=1, DEPTH=256; assert i_reset 1 cycle, then hold i_req=1 -> o_ready=0 and o_busy=1 for exactly 256 cycles, no o_rsp_valid; then LW 0x3FC -> o_rsp_valid, o_rdata=0, o_fault=00.
- SW 0x10 data 0x8899AABB; SB 0x11 data 0x000000CC; LW 0x10 -> 0x8899CCBB; LB 0x11 -> 0xFFFFFFCC; LBU 0x11 -> 0x000000CC; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
- Back-to-back SH 0x20 data 0x1234 then LW 0x20 on the next cycle -> 0x00001234, one response per cycle, no bubbles.
- SW 0x22 data 0xFFFFFFFF -> o_fault=01, o_rdata=0; following LW 0x20 still returns 0x00001234. LH 0x21 -> fault 01.
- LW 0x400 (index 256) -> fault 10. Load with i_size=011 -> fault 10. SB with i_size=100 -> fault 10, memory unchanged.
- Assert i_reset in the cycle a load is accepted -> no o_rsp_valid next cycle; INIT restarts and afterwards LW 0x10 returns 0.
